sseg_mux_driver: RTL and testbench
==================================

// Module: sseg_mux_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver; scans digits with active-low anodes/segments.
//  Per-digit hex value, decimal point and blank enable; frame-synchronous shadow update (no tearing).
//  Anti-ghosting blank interval at the start of every digit slot.
//  Sits between the CPU/IO register slot and board display pins; one instance per display bank.
// PARAMETERS
//  N_DIGITS      8       number of digits scanned, 2..16
//  REFRESH_DIV   100000  clk cycles per digit slot; must be >= BLANK_CYCLES+1
//  BLANK_CYCLES  1000    cycles at slot start with all anodes off; 0 disables
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  load         in   1           1-cycle strobe: capture hex_in/dp_in/blank_in into staging
//  hex_in       in   4*N_DIGITS  digit i value = hex_in[4i+3:4i]
//  dp_in        in   N_DIGITS    1 = light decimal point of digit i
//  blank_in     in   N_DIGITS    1 = digit i dark (anode held off)
//  pending      out  1           staging holds data not yet shown
//  frame_tick   out  1           1-cycle pulse when scan wraps digit N-1 -> 0
//  an           out  N_DIGITS    anodes, active low, one-hot-low or all 1
//  sseg         out  8           {dp, g..a}, active low
// BEHAVIOUR
//  Reset: an='1, sseg=8'hFF, pending=0, frame_tick=0; prescaler=0, digit index=0;
//   staging/active hex=0, dp=0, blank='1 (display dark until first load is transferred).
//  Prescaler counts 0..REFRESH_DIV-1; at terminal count digit index increments, wraps N_DIGITS-1 -> 0.
//  Frame = N_DIGITS*REFRESH_DIV cycles; frame_tick asserts on the cycle of the wrap.
//  Slot cycles 0..BLANK_CYCLES-1: an='1, sseg=8'hFF. Remaining cycles: an[idx]=0 unless active blank[idx].
//  Blanked digit: an='1, sseg=8'hFF for the whole slot.
//  an/sseg registered: reflect prescaler/index state of previous cycle (1-cycle latency).
//  Segment codes g..a (active low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//   A=08 B=03 C=46 D=21 E=06 F=0E; sseg[7]=~dp.
//  load: staging <= inputs, pending <= 1. load while pending: staging overwritten (last wins).
//  Frame wrap with pending=1: active <= staging, pending <= 0. Active never changes mid-frame.
//  Simultaneous load and wrap: active <= staging content before this load; staging <= new inputs;
//   pending stays 1 (new data shown at next wrap).
//  Reset mid-frame: all state returns to reset values next cycle; pending data discarded.
// CONFIGURATION
//  SSEG_LEADING_ZERO_BLANK_EN defined: scanning from digit N_DIGITS-1 down, each digit with
//   hex==0 and dp==0 is blanked until the first nonzero or dp digit; digit 0 never auto-blanked;
//   ORed with active blank. Computed from active registers only (changes only at wrap).
//  Undefined: only blank_in controls blanking; zeros displayed as 8'hC0.
// STRUCTURE
//  sseg_pkg: segment-code constant table, function hex_to_seg7(logic [3:0]) -> logic [6:0],
//   localparam-friendly types for digit index width ($clog2(N_DIGITS)).
//  Sub-module sseg_tick_gen: prescaler, emits slot_start, in_blank and slot_end strobes.
//  Top: staging/active registers, digit index, leading-zero logic, output registers.
// TESTING  (N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted)
//  Reset held 3 cycles, released -> an=4'hF, sseg=8'hFF, pending=0 for the whole first frame.
//  load hex=16'h12AF dp=4'b0010 blank=0 -> pending=1 until wrap; next frame per slot after 1 blank
//   cycle: an=1110 sseg=8E; an=1101 sseg=08; an=1011 sseg=A4; an=0111 sseg=F9; pending=0.
//  load 16'h0000 then 16'h0007 within one frame -> only 7 shown next frame (digit0 sseg=F8).
//  load coincident with frame_tick -> frame shows prior staging; new value at following wrap.
//  With SSEG_LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3,2 an never low; digit1 sseg=92,
//   digit0 sseg=C0. Without macro -> digits 3,2 show C0.
//  BLANK_CYCLES=0, blank_in=4'b0101 -> digits 0,2 dark, digits 1,3 low for all 4 slot cycles;
//   reset asserted mid-slot -> an=4'hF next cycle.

Source files
------------

// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the seven-segment scan driver:
//   SEG_OFF      all segments (and the decimal point) dark, active low
//   idx_width()  width of a digit index for a given digit count
//   hex_to_seg7  4-bit value -> active-low segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package sseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Width of a digit index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// ---------------------------------------------------------------------------
// sseg_tick_gen
// Digit-slot prescaler. Counts 0..REFRESH_DIV-1 and flags where the scan
// currently is inside a slot.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous, active-high reset (counter -> 0)
//   in_blank_o  current cycle is inside the anti-ghosting window
//   slot_end_o  current cycle is the last cycle of the slot
//   pre_end_o   next cycle will be the last cycle of the slot
// ---------------------------------------------------------------------------
module sseg_tick_gen #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic in_blank_o,
    output logic slot_end_o,
    output logic pre_end_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Prescaler next state: wrap at the terminal count.
    always_comb begin
        presc_d = presc_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Slot strobes. A one-cycle slot is always about to end; a zero-length
    // blank window makes the compare below constant false.
    always_comb begin
        in_blank_o = (presc_q < PW'(BLANK_CYCLES));
        slot_end_o = (presc_q == PW'(REFRESH_DIV - 1));
        if (REFRESH_DIV == 1) begin
            pre_end_o = 1'b1;
        end else begin
            pre_end_o = (presc_q == PW'(REFRESH_DIV - 2));
        end
    end

endmodule

// File: rtl/sseg_mux_driver.sv
// ---------------------------------------------------------------------------
// sseg_mux_driver
// Time-multiplexed N-digit seven-segment driver with active-low anodes and
// segments. New digit data is staged by 'load' and copied into the active
// set only when the scan wraps from the last digit to digit 0, so a frame
// never shows a mix of old and new data. Each slot begins with a short
// window with every anode off to suppress ghosting.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         strobe: capture hex_in/dp_in/blank_in into staging
//   hex_in       4 bits per digit, digit i at [4i+3:4i]
//   dp_in        per-digit decimal point enable
//   blank_in     per-digit dark enable
//   pending      staging holds data not yet shown
//   frame_tick   high during the last cycle of each frame
//   an           anodes, active low (one low or all high)
//   sseg         {dp,g..a}, active low
// Build option: define SSEG_LEADING_ZERO_BLANK_EN to darken leading zero
// digits (digit 0 is always shown).
// ---------------------------------------------------------------------------
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    output logic                    pending,
    output logic                    frame_tick,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg
);

    localparam int                IW       = idx_width(N_DIGITS);
    localparam logic [IW-1:0]     IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic                    in_blank_s;
    logic                    slot_end_s;
    logic                    pre_end_s;
    logic                    wrap_s;

    logic [4*N_DIGITS-1:0]   stg_hex_q;
    logic [N_DIGITS-1:0]     stg_dp_q;
    logic [N_DIGITS-1:0]     stg_blank_q;
    logic [4*N_DIGITS-1:0]   act_hex_q;
    logic [N_DIGITS-1:0]     act_dp_q;
    logic [N_DIGITS-1:0]     act_blank_q;
    logic                    pending_q;
    logic                    pending_d;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic                    frame_tick_q;
    logic                    frame_tick_d;
    logic [N_DIGITS-1:0]     an_q;
    logic [N_DIGITS-1:0]     an_d;
    logic [7:0]              sseg_q;
    logic [7:0]              sseg_d;

    logic [3:0]              act_digit_s [N_DIGITS];
    logic [N_DIGITS-1:0]     lz_blank_s;
    logic [N_DIGITS-1:0]     eff_blank_s;

    sseg_tick_gen #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk_i      (clk),
        .reset_i    (reset),
        .in_blank_o (in_blank_s),
        .slot_end_o (slot_end_s),
        .pre_end_o  (pre_end_s)
    );

    assign wrap_s = slot_end_s && (idx_q == IDX_LAST);

    // Scan index, pending flag and frame-tick look-ahead next state.
    always_comb begin
        idx_d = idx_q;
        if (slot_end_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        // A load on the wrap cycle keeps pending set: the transfer takes
        // the older staging contents and the new data waits a frame.
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (wrap_s && pending_q) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // Registered so that it is high during the wrap cycle itself.
        frame_tick_d = pre_end_s && (idx_d == IDX_LAST);
    end

    // Staging registers: last load wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_hex_q   <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '1;
        end else if (load) begin
            stg_hex_q   <= hex_in;
            stg_dp_q    <= dp_in;
            stg_blank_q <= blank_in;
        end else begin
            stg_hex_q   <= stg_hex_q;
            stg_dp_q    <= stg_dp_q;
            stg_blank_q <= stg_blank_q;
        end
    end

    // Active registers: only ever change on the frame wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
        end else if (wrap_s && pending_q) begin
            act_hex_q   <= stg_hex_q;
            act_dp_q    <= stg_dp_q;
            act_blank_q <= stg_blank_q;
        end else begin
            act_hex_q   <= act_hex_q;
            act_dp_q    <= act_dp_q;
            act_blank_q <= act_blank_q;
        end
    end

    // Scan state and control flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Split the active hex word into per-digit nibbles.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            act_digit_s[i] = act_hex_q[4*i +: 4];
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Leading-zero suppression from the top digit down; a set decimal point
    // counts as significant. Digit 0 is never suppressed.
    always_comb begin
        logic leading_v;
        lz_blank_s = '0;
        leading_v  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (leading_v && (act_digit_s[i] == 4'h0) && !act_dp_q[i]) begin
                lz_blank_s[i] = 1'b1;
            end else begin
                leading_v = 1'b0;
            end
        end
    end
`else
    // Leading zeros are displayed normally.
    always_comb begin
        lz_blank_s = '0;
    end
`endif

    assign eff_blank_s = act_blank_q | lz_blank_s;

    // Output pattern for the current scan position.
    always_comb begin
        an_d   = '1;
        sseg_d = SEG_OFF;
        if (in_blank_s || eff_blank_s[idx_q]) begin
            an_d   = '1;
            sseg_d = SEG_OFF;
        end else begin
            an_d   = ~(ONE_HOT0 << idx_q);
            sseg_d = {~act_dp_q[idx_q], hex_to_seg7(act_digit_s[idx_q])};
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q   <= '1;
            sseg_q <= SEG_OFF;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver with N_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
// 'dut' uses a one-cycle blank window, 'dut0' none; both share all inputs.
// cyc counts clock edges since reset release; the scan position equals
// cyc mod 16 and outputs show the position of the previous cycle.
module tb_sseg_mux_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        pending, frame_tick, pending0, frame_tick0;
    logic [3:0]  an, an0;
    logic [7:0]  sseg, sseg0;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .pending(pending), .frame_tick(frame_tick),
        .an(an), .sseg(sseg)
    );

    sseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .pending(pending0), .frame_tick(frame_tick0),
        .an(an0), .sseg(sseg0)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  vis;   // digits expected to light
        logic [31:0] segs;  // {d3,d2,d1,d0} expected sseg when lit
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (((cyc % 16) != p) && (guard < 40)) begin
            tick();
            guard++;
        end
        chk("wait_pos", cyc % 16, p);
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
        load     = 1'b1;
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_an_sseg", {an, sseg}, {4'hF, 8'hFF});
        chk("rst_pend_ft", {pending, frame_tick}, 2'b00);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // A full frame with nothing shown, nothing pending.
    task automatic check_dark_frame();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("dark_an_sseg", {an, sseg}, {4'hF, 8'hFF});
            chk("dark_an0", an0, 4'hF);
            chk("dark_pend", pending, 1'b0);
            chk("dark_ftick", frame_tick, ((cyc % 16) == 15) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an;
        logic [7:0] exp_seg;

        vecs[0] = '{16'h12AF, 4'b0010, 4'b0000, 4'b1111, 32'hF9A4_088E};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 4'b0011, 32'hFFFF_92C0};
`else
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 4'b1111, 32'hC0C0_92C0};
`endif
        vecs[2] = '{16'hDC98, 4'b0100, 4'b1000, 4'b0111, 32'hFF46_9080};
        vecs[3] = '{16'h3456, 4'b1111, 4'b0000, 4'b1111, 32'h3019_1202};
        vecs[4] = '{16'hE0B0, 4'b0000, 4'b0000, 4'b1111, 32'h86C0_83C0};
        vecs[5] = '{16'h0000, 4'b1000, 4'b0000, 4'b1111, 32'h40C0_C0C0};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        vecs[6] = '{16'h0000, 4'b0000, 4'b0000, 4'b0001, 32'hFFFF_FFC0};
`else
        vecs[6] = '{16'h0000, 4'b0000, 4'b0000, 4'b1111, 32'hC0C0_C0C0};
`endif
        vecs[7] = '{16'h7777, 4'b0000, 4'b1111, 4'b0000, 32'hFFFF_FFFF};

        reset = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;

        // Reset held 3 cycles; first frame stays dark.
        do_reset(3);
        check_dark_frame();

        // Table: load mid-frame, verify the following frame slot by slot.
        for (int v = 0; v < 8; v++) begin
            wait_pos(2);
            do_load(vecs[v].hex, vecs[v].dp, vecs[v].blank);
            chk("pend_set", pending, 1'b1);
            wait_pos(15);
            chk("ftick_wrap", frame_tick, 1'b1);
            chk("pend_hold", pending, 1'b1);
            wait_pos(0);
            chk("pend_clr", pending, 1'b0);
            chk("ftick_low", frame_tick, 1'b0);
            for (int d = 0; d < 4; d++) begin
                wait_pos(4 * d + 1);
                chk("slot_blank", {an, sseg}, {4'hF, 8'hFF});
                wait_pos(4 * d + 2);
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
                if (vecs[v].vis[d]) begin
                    exp_an[d] = 1'b0;
                    exp_seg   = vecs[v].segs[8*d +: 8];
                end
                chk("digit", {an, sseg}, {exp_an, exp_seg});
            end
        end

        // Two loads in one frame: the later one wins.
        wait_pos(2);
        do_load(16'h0000, 4'h0, 4'h0);
        wait_pos(6);
        do_load(16'h0007, 4'h0, 4'h0);
        wait_pos(0);
        chk("lw_pend_clr", pending, 1'b0);
        wait_pos(2);
        chk("lw_digit0", {an, sseg}, {4'b1110, 8'hF8});
        wait_pos(6);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        chk("lw_digit1", {an, sseg}, {4'hF, 8'hFF});
`else
        chk("lw_digit1", {an, sseg}, {4'b1101, 8'hC0});
`endif

        // Load coinciding with frame_tick: prior staging shown first.
        wait_pos(2);
        do_load(16'h1111, 4'h0, 4'h0);
        wait_pos(15);
        chk("co_ftick", frame_tick, 1'b1);
        do_load(16'h2222, 4'h0, 4'h0);
        chk("co_pend_stays", pending, 1'b1);
        wait_pos(2);
        chk("co_old_shown", {an, sseg}, {4'b1110, 8'hF9});
        wait_pos(0);
        chk("co_pend_clr", pending, 1'b0);
        wait_pos(2);
        chk("co_new_shown", {an, sseg}, {4'b1110, 8'hA4});

        // No blank window: digits 1,3 lit for every slot cycle, 0,2 dark.
        wait_pos(2);
        do_load(16'h4321, 4'h0, 4'b0101);
        wait_pos(0);
        for (int p = 5; p <= 8; p++) begin
            wait_pos(p % 16);
            chk("nb_digit1", {an0, sseg0}, {4'b1101, 8'hA4});
            if (p == 5) chk("nb_ref_blank", an, 4'hF);
        end
        for (int p = 9; p <= 12; p++) begin
            wait_pos(p % 16);
            chk("nb_digit2_dark", {an0, sseg0}, {4'hF, 8'hFF});
        end
        for (int p = 13; p <= 16; p++) begin
            wait_pos(p % 16);
            chk("nb_digit3", {an0, sseg0}, {4'b0111, 8'h99});
            if (p == 15) chk("nb_ftick", frame_tick0, 1'b1);
        end
        for (int p = 1; p <= 2; p++) begin
            wait_pos(p);
            chk("nb_digit0_dark", {an0, sseg0}, {4'hF, 8'hFF});
        end

        // Reset mid-slot with data pending: dark next cycle, data discarded.
        wait_pos(3);
        do_load(16'h8888, 4'h0, 4'h0);
        chk("mr_pend0", pending0, 1'b1);
        wait_pos(6);
        chk("mr_lit", an0, 4'b1101);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_an0", {an0, sseg0}, {4'hF, 8'hFF});
        chk("mr_pend0_clr", pending0, 1'b0);
        chk("mr_an", {an, sseg}, {4'hF, 8'hFF});
        do_reset(1);
        check_dark_frame();
        wait_pos(2);
        chk("mr_still_dark", {an, an0}, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
